// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store data port: one outstanding word
// access, fixed response latency, valid/ready on both request and response.
//
// state | meaning
// IDLE  | ready for a request (req_ready high after the first post-reset edge)
// BUSY  | access accepted, latency down-counter running
// RESP  | response presented, held until rsp_ready
module data_mem_responder #(
  parameter int DATA_WIDTH        = 32,
  parameter int RAM_ADDRESS_WIDTH = 18,
  parameter int LATENCY           = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [RAM_ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err
);

  localparam int         IDX_W   = RAM_ADDRESS_WIDTH - 2;
  localparam int         WORDS   = 1 << IDX_W;
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              cnt;
  logic [3:0]              cnt_next;

  logic                    we_q;
  logic                    err_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   mem [WORDS];

  logic                    accept;
  logic                    req_err;
  logic                    mem_wr;
  logic                    resp_enter;
  logic                    resp_done;

  // State register; req_ready is registered so it stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      req_ready <= (state_next == IDLE);
    end
  end

  // The counter is loaded with the full latency so the edge that sees it at 1
  // is exactly LATENCY edges after acceptance.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = LAT_CNT;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_comb begin
    accept     = req_valid && req_ready;
    req_err    = (req_addr[1:0] != 2'b00);
    mem_wr     = accept && req_we && !req_err;
    resp_enter = (state == BUSY) && (cnt == 4'd1);
    resp_done  = (state == RESP) && rsp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      we_q  <= req_we;
      err_q <= req_err;
      idx_q <= req_addr[RAM_ADDRESS_WIDTH-1:2];
    end
  end

  // Load data is sampled on the RESP entry edge, after any earlier store commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (resp_enter) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err_q;
      rsp_rdata <= (!we_q && !err_q) ? mem[idx_q] : '0;
    end else if (resp_done) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[req_addr[RAM_ADDRESS_WIDTH-1:2]] <= req_wdata;
    end
  end

endmodule
